// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline stage register: the upstream
// valid/ready beat, the downstream valid/ready beat, the hazard-unit
// flush and the occupancy report.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 6,
   parameter int REG_W  = 5
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic [REG_W-1:0]  in_wrin;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [REG_W-1:0]  out_wrin;
   logic [1:0]        occupancy;

   // Producer/consumer side (drives beats in, accepts beats out)
   modport master (
      output in_valid, in_data, in_ctrl, in_wrin, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, out_wrin, occupancy
   );

   // Stage register side
   modport slave (
      input  in_valid, in_data, in_ctrl, in_wrin, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, out_wrin, occupancy
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, stall, flush-to-bubble
// and an optional 2-entry skid buffer. A bubble carries zero control bits
// and a zero destination register, so it behaves as a NOP downstream.
// SKID=1: main + skid entry, in_ready is a register.
// SKID=0: single main entry, in_ready = out_ready | !out_valid.
module pipe_stage_skid #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 6,
   parameter int REG_W  = 5,
   parameter int SKID   = 1
) (
   input logic             CLK,
   input logic             RESET_N,
   pipe_stage_skid_if.slave bus
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;
   localparam logic       USE_SKID = (SKID != 0);

   logic [1:0]        state_q, state_d;
   logic              valid_q;
   logic              in_ready_q;
   logic [DATA_W-1:0] data_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [REG_W-1:0]  wrin_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [REG_W-1:0]  skid_wrin_q;

   logic in_ready;
   logic in_fire;
   logic out_fire;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   // Without a skid entry the stage can only take a beat when the held one
   // leaves in the same cycle (or nothing is held).
   assign in_ready = USE_SKID ? in_ready_q : (bus.out_ready | ~valid_q);
   assign in_fire  = bus.in_valid & in_ready;
   assign out_fire = valid_q & bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_ctrl  = ctrl_q;
   assign bus.out_wrin  = wrin_q;
   assign bus.occupancy = state_q;

   // Next-state and load selection; flush overrides any handshake.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d      = ST_ONE;
                  load_main_in = 1'b1;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  state_d      = ST_ONE;
                  load_main_in = 1'b1;
               end else if (in_fire && USE_SKID) begin
                  state_d   = ST_FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d        = ST_ONE;
                  load_main_skid = 1'b1;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Control registers: state, output valid and the registered in_ready.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= ST_EMPTY;
         valid_q    <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= (state_d != ST_EMPTY);
         in_ready_q <= (state_d != ST_FULL);
      end
   end

   // Main (output) entry; control and destination drop to zero on a bubble,
   // the payload keeps its last value.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         data_q <= {DATA_W{1'b0}};
         ctrl_q <= {CTRL_W{1'b0}};
         wrin_q <= {REG_W{1'b0}};
      end else begin
         if (load_main_in) begin
            data_q <= bus.in_data;
         end else if (load_main_skid) begin
            data_q <= skid_data_q;
         end else begin
            data_q <= data_q;
         end
         if (state_d == ST_EMPTY) begin
            ctrl_q <= {CTRL_W{1'b0}};
            wrin_q <= {REG_W{1'b0}};
         end else if (load_main_in) begin
            ctrl_q <= bus.in_ctrl;
            wrin_q <= bus.in_wrin;
         end else if (load_main_skid) begin
            ctrl_q <= skid_ctrl_q;
            wrin_q <= skid_wrin_q;
         end else begin
            ctrl_q <= ctrl_q;
            wrin_q <= wrin_q;
         end
      end
   end

   // Skid entry: catches the beat accepted while the output is stalled.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         skid_data_q <= {DATA_W{1'b0}};
         skid_ctrl_q <= {CTRL_W{1'b0}};
         skid_wrin_q <= {REG_W{1'b0}};
      end else if (bus.flush) begin
         skid_data_q <= {DATA_W{1'b0}};
         skid_ctrl_q <= {CTRL_W{1'b0}};
         skid_wrin_q <= {REG_W{1'b0}};
      end else if (load_skid) begin
         skid_data_q <= bus.in_data;
         skid_ctrl_q <= bus.in_ctrl;
         skid_wrin_q <= bus.in_wrin;
      end else begin
         skid_data_q <= skid_data_q;
         skid_ctrl_q <= skid_ctrl_q;
         skid_wrin_q <= skid_wrin_q;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one instance with the skid entry and
// one without, driven from a shared clock and reset.
module tb_pipe_stage_skid;

   logic CLK;
   logic RESET_N;
   int   n_checks;
   int   n_errors;

   pipe_stage_skid_if #(.DATA_W(96), .CTRL_W(6), .REG_W(5)) bus1 ();
   pipe_stage_skid_if #(.DATA_W(96), .CTRL_W(6), .REG_W(5)) bus0 ();

   pipe_stage_skid #(.DATA_W(96), .CTRL_W(6), .REG_W(5), .SKID(1)) dut_skid (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus1)
   );

   pipe_stage_skid #(.DATA_W(96), .CTRL_W(6), .REG_W(5), .SKID(0)) dut_noskid (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [95:0] d, input logic [5:0] c, input logic [4:0] w);
      bus1.in_valid = v;
      bus1.in_data  = d;
      bus1.in_ctrl  = c;
      bus1.in_wrin  = w;
   endtask

   task automatic drive0(input logic v, input logic [95:0] d, input logic [5:0] c, input logic [4:0] w);
      bus0.in_valid = v;
      bus0.in_data  = d;
      bus0.in_ctrl  = c;
      bus0.in_wrin  = w;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;

      // ---------------- reset with garbage on the inputs ----------------
      RESET_N = 1'b0;
      drive1(1'b1, 96'hDEAD_BEEF, 6'h2A, 5'd19);
      drive0(1'b1, 96'hBAD_CAFE, 6'h15, 5'd9);
      bus1.flush = 1'b0; bus1.out_ready = 1'b1;
      bus0.flush = 1'b0; bus0.out_ready = 1'b1;
      cyc();
      cyc();
      check("rst_valid",  bus1.out_valid, 1'b0);
      check("rst_ctrl",   bus1.out_ctrl, 6'h0);
      check("rst_wrin",   bus1.out_wrin, 5'd0);
      check("rst_occ",    bus1.occupancy, 2'd0);
      check("rst_ready",  bus1.in_ready, 1'b0);
      check("rst_valid0", bus0.out_valid, 1'b0);
      check("rst_occ0",   bus0.occupancy, 2'd0);

      RESET_N = 1'b1;
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      drive0(1'b0, 96'h0, 6'h0, 5'd0);
      cyc();
      check("post_rst_ready", bus1.in_ready, 1'b1);
      check("post_rst_valid", bus1.out_valid, 1'b0);
      check("post_rst_valid0", bus0.out_valid, 1'b0);
      cyc();
      check("post_rst_nobeat", bus1.out_valid, 1'b0);

      // ---------------- streaming, SKID=1 ----------------
      bus1.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive1(1'b1, 96'(i), 6'h3F, 5'd5);
         cyc();
         check("stream_valid", bus1.out_valid, 1'b1);
         check("stream_data",  bus1.out_data, 96'(i));
         check("stream_ctrl",  bus1.out_ctrl, 6'h3F);
         check("stream_occ",   bus1.occupancy, 2'd1);
         check("stream_ready", bus1.in_ready, 1'b1);
      end
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      cyc();
      check("stream_end_valid", bus1.out_valid, 1'b0);
      check("stream_end_ctrl",  bus1.out_ctrl, 6'h0);
      check("stream_end_occ",   bus1.occupancy, 2'd0);

      // ---------------- stall fills the skid entry ----------------
      bus1.out_ready = 1'b0;
      drive1(1'b1, 96'hA, 6'h11, 5'd1);
      cyc();
      check("stall_a_data",  bus1.out_data, 96'hA);
      check("stall_a_occ",   bus1.occupancy, 2'd1);
      check("stall_a_ready", bus1.in_ready, 1'b1);
      drive1(1'b1, 96'hB, 6'h22, 5'd2);
      cyc();
      check("stall_full_occ",   bus1.occupancy, 2'd2);
      check("stall_full_ready", bus1.in_ready, 1'b0);
      check("stall_full_data",  bus1.out_data, 96'hA);
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      cyc();
      check("stall_hold_data", bus1.out_data, 96'hA);
      check("stall_hold_ctrl", bus1.out_ctrl, 6'h11);
      check("stall_hold_occ",  bus1.occupancy, 2'd2);
      bus1.out_ready = 1'b1;
      cyc();
      check("release_b_data", bus1.out_data, 96'hB);
      check("release_b_ctrl", bus1.out_ctrl, 6'h22);
      check("release_b_wrin", bus1.out_wrin, 5'd2);
      check("release_b_occ",  bus1.occupancy, 2'd1);
      check("release_ready",  bus1.in_ready, 1'b1);
      cyc();
      check("release_empty_occ",   bus1.occupancy, 2'd0);
      check("release_empty_valid", bus1.out_valid, 1'b0);

      // ---------------- flush while FULL, C offered in flush cycle ----------------
      bus1.out_ready = 1'b0;
      drive1(1'b1, 96'hD, 6'h01, 5'd4);
      cyc();
      drive1(1'b1, 96'hE, 6'h02, 5'd6);
      cyc();
      check("pre_flush_occ", bus1.occupancy, 2'd2);
      drive1(1'b1, 96'hC, 6'h3F, 5'd3);
      bus1.flush = 1'b1;
      cyc();
      bus1.flush = 1'b0;
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      check("flush_valid", bus1.out_valid, 1'b0);
      check("flush_ctrl",  bus1.out_ctrl, 6'h0);
      check("flush_wrin",  bus1.out_wrin, 5'd0);
      check("flush_occ",   bus1.occupancy, 2'd0);
      check("flush_ready", bus1.in_ready, 1'b1);
      bus1.out_ready = 1'b1;
      cyc();
      check("flush_no_c", bus1.out_valid, 1'b0);

      // ---------------- flush in ONE discards an in_fire ----------------
      drive1(1'b1, 96'hF, 6'h07, 5'd8);
      cyc();
      check("one_pre_flush_valid", bus1.out_valid, 1'b1);
      drive1(1'b1, 96'hC, 6'h3F, 5'd3);
      bus1.flush = 1'b1;
      cyc();
      bus1.flush = 1'b0;
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      check("one_flush_valid", bus1.out_valid, 1'b0);
      check("one_flush_wrin",  bus1.out_wrin, 5'd0);
      cyc();
      check("one_flush_no_c", bus1.out_valid, 1'b0);

      // ---------------- bubble after a single beat ----------------
      drive1(1'b1, 96'h77, 6'h15, 5'd7);
      cyc();
      check("bubble_beat_ctrl", bus1.out_ctrl, 6'h15);
      check("bubble_beat_wrin", bus1.out_wrin, 5'd7);
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      cyc();
      check("bubble_valid", bus1.out_valid, 1'b0);
      check("bubble_ctrl",  bus1.out_ctrl, 6'h0);
      check("bubble_wrin",  bus1.out_wrin, 5'd0);
      check("bubble_data",  bus1.out_data, 96'h77);

      // ---------------- reset mid-operation while FULL ----------------
      bus1.out_ready = 1'b0;
      drive1(1'b1, 96'h31, 6'h05, 5'd10);
      cyc();
      drive1(1'b1, 96'h32, 6'h06, 5'd11);
      cyc();
      check("mid_rst_pre_occ", bus1.occupancy, 2'd2);
      RESET_N = 1'b0;
      cyc();
      check("mid_rst_occ",   bus1.occupancy, 2'd0);
      check("mid_rst_valid", bus1.out_valid, 1'b0);
      check("mid_rst_ready", bus1.in_ready, 1'b0);
      check("mid_rst_data",  bus1.out_data, 96'h0);
      RESET_N = 1'b1;
      drive1(1'b0, 96'h0, 6'h0, 5'd0);
      bus1.out_ready = 1'b1;
      cyc();
      check("mid_rst_after_ready", bus1.in_ready, 1'b1);
      check("mid_rst_after_valid", bus1.out_valid, 1'b0);

      // ---------------- SKID=0 stall scenario ----------------
      bus0.out_ready = 1'b0;
      #1;
      check("ns_idle_ready", bus0.in_ready, 1'b1);
      drive0(1'b1, 96'hA, 6'h11, 5'd1);
      cyc();
      check("ns_a_valid", bus0.out_valid, 1'b1);
      check("ns_a_data",  bus0.out_data, 96'hA);
      check("ns_a_occ",   bus0.occupancy, 2'd1);
      drive0(1'b1, 96'hB, 6'h22, 5'd2);
      #1;
      check("ns_stall_ready", bus0.in_ready, 1'b0);
      cyc();
      check("ns_stall_data", bus0.out_data, 96'hA);
      check("ns_stall_occ",  bus0.occupancy, 2'd1);
      cyc();
      check("ns_stall2_data", bus0.out_data, 96'hA);
      check("ns_stall2_occ",  bus0.occupancy, 2'd1);
      bus0.out_ready = 1'b1;
      #1;
      check("ns_release_ready", bus0.in_ready, 1'b1);
      cyc();
      check("ns_b_data", bus0.out_data, 96'hB);
      check("ns_b_ctrl", bus0.out_ctrl, 6'h22);
      check("ns_b_occ",  bus0.occupancy, 2'd1);
      drive0(1'b0, 96'h0, 6'h0, 5'd0);
      cyc();
      check("ns_end_valid", bus0.out_valid, 1'b0);
      check("ns_end_wrin",  bus0.out_wrin, 5'd0);
      check("ns_end_occ",   bus0.occupancy, 2'd0);
      check("ns_end_data",  bus0.out_data, 96'hB);

      // ---------------- SKID=0 flush ----------------
      drive0(1'b1, 96'h5, 6'h09, 5'd12);
      cyc();
      drive0(1'b1, 96'hC, 6'h3F, 5'd3);
      bus0.flush = 1'b1;
      cyc();
      bus0.flush = 1'b0;
      drive0(1'b0, 96'h0, 6'h0, 5'd0);
      check("ns_flush_valid", bus0.out_valid, 1'b0);
      check("ns_flush_ctrl",  bus0.out_ctrl, 6'h0);
      cyc();
      check("ns_flush_no_c", bus0.out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
